// File: rtl/risc_ctrl_fsm_pkg.sv
// Shared opcodes, state/select encodings and opcode classifier for the RISC control sequencer.
// RISC_STACK_OPS_EN: when defined, PUSH/POP/CALL/RET classify as stack ops; otherwise they are illegal.
package risc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MOVE  = 6'b000001;
  localparam logic [5:0] OP_LD    = 6'b010000;
  localparam logic [5:0] OP_ST    = 6'b010001;
  localparam logic [5:0] OP_PUSH  = 6'b010010;
  localparam logic [5:0] OP_POP   = 6'b010011;
  localparam logic [5:0] OP_CALL  = 6'b010100;
  localparam logic [5:0] OP_RET   = 6'b010101;
  localparam logic [5:0] OP_BEQ   = 6'b011001;
  localparam logic [5:0] OP_NOP   = 6'b111110;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {RESET_S, FETCH, DECODE, EXEC, MEM, WB1, WB2, HALT_S} state_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_CALL, PC_MEM} pc_sel_e;
  typedef enum logic [1:0] {WD_RD, WD_RT, WD_SP} rf_wdst_e;
  typedef enum logic [1:0] {WS_ALU, WS_MEM, WS_SPP4, WS_SPM4} rf_wsrc_e;
  typedef enum logic [1:0] {MA_PC, MA_ALU, MA_SP, MA_SPM4} mem_addr_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_MOVE, C_LD, C_ST, C_BEQ,
    C_PUSH, C_POP, C_CALL, C_RET, C_NOP, C_HALT, C_ILL
  } op_class_e;

  // I-type ALU ops occupy the 001xxx block.
  function automatic op_class_e op_class(input logic [5:0] op);
    op_class_e c;
    c = C_ILL;
    case (op) inside
      OP_RTYPE:   c = C_ALU_R;
      OP_MOVE:    c = C_MOVE;
      6'b001???:  c = C_ALU_I;
      OP_LD:      c = C_LD;
      OP_ST:      c = C_ST;
      OP_BEQ:     c = C_BEQ;
      OP_NOP:     c = C_NOP;
      OP_HALT:    c = C_HALT;
`ifdef RISC_STACK_OPS_EN
      OP_PUSH:    c = C_PUSH;
      OP_POP:     c = C_POP;
      OP_CALL:    c = C_CALL;
      OP_RET:     c = C_RET;
`endif
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// Shared instruction/data memory handshake between the sequencer (master) and memory (slave).
interface risc_ctrl_fsm_if;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_addr_sel;
  logic       mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/risc_ctrl_fsm_timer.sv
// Memory wait counter: counts stalled request cycles and flags the MEM_TIMEOUT-th one.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic timeout
);
  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (!waiting)     cnt <= '0;
    else if (cnt != LAST)  cnt <= cnt + 1'b1;
  end

  // Only a stalled cycle can time out, so a same-cycle mem_ready always wins.
  assign timeout = waiting && (cnt == LAST);
endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/writeback with memory handshake.
// Stack ops (PUSH/POP/CALL/RET) are sequenced only when RISC_STACK_OPS_EN is defined.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero_flag,
  risc_ctrl_fsm_if.master  bus,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_imm,
  output logic             alu_op_sel,
  output logic             rf_we,
  output logic [1:0]       rf_wdst,
  output logic [1:0]       rf_wsrc,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_e    st, nxt;
  logic [5:0] op_q;
  op_class_e cls_d, cls_q;
  logic      req, we, tmo, retire;
  logic [1:0] asel;

  // funct steers the ALU directly when alu_op_sel=0; the sequencer never needs it.
  logic unused_funct;
  assign unused_funct = ^funct;

  assign cls_d = op_class(opcode);
  assign cls_q = op_class(op_q);

  assign bus.mem_req      = req;
  assign bus.mem_we       = we;
  assign bus.mem_addr_sel = asel;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (req && !bus.mem_ready),
    .timeout (tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= RESET_S;
      op_q    <= '0;
      bus_err <= 1'b0;
      retired <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE) op_q <= opcode;
      if (tmo) bus_err <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // An instruction retires when control returns to FETCH or first enters HALT_S.
  assign retire = ((nxt == FETCH) && (st inside {EXEC, WB1, WB2})) ||
                  ((nxt == HALT_S) && (st != HALT_S));

  always_comb begin
    nxt         = st;
    req         = 1'b0;
    we          = 1'b0;
    asel        = MA_PC;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    alu_src_imm = 1'b0;
    alu_op_sel  = 1'b0;
    rf_we       = 1'b0;
    rf_wdst     = WD_RD;
    rf_wsrc     = WS_ALU;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (st)
      RESET_S: nxt = FETCH;
      FETCH: begin
        req = 1'b1;
        if (bus.mem_ready) begin
          ir_we = 1'b1;
          nxt   = DECODE;
        end else if (tmo) begin
          nxt = HALT_S;
        end
      end
      DECODE: begin
        case (cls_d)
          C_HALT: nxt = HALT_S;
          C_NOP:  nxt = WB1;
          C_ILL: begin
            illegal = 1'b1;
            nxt     = WB1;
          end
          default: nxt = EXEC;
        endcase
      end
      EXEC: begin
        alu_op_sel  = cls_q inside {C_ALU_I, C_MOVE, C_LD, C_ST, C_BEQ};
        alu_src_imm = cls_q inside {C_ALU_I, C_LD, C_ST};
        case (cls_q)
          C_BEQ: begin
            pc_we  = 1'b1;
            pc_sel = zero_flag ? PC_BRANCH : PC_PLUS4;
            nxt    = FETCH;
          end
          C_ALU_R, C_ALU_I, C_MOVE: nxt = WB1;
          default: nxt = MEM;
        endcase
      end
      MEM: begin
        req = 1'b1;
        case (cls_q)
          C_ST: begin
            we   = 1'b1;
            asel = MA_ALU;
          end
          C_PUSH, C_CALL: begin
            we   = 1'b1;
            asel = MA_SPM4;
          end
          C_POP, C_RET: asel = MA_SP;
          default:      asel = MA_ALU;
        endcase
        if (bus.mem_ready) nxt = WB1;
        else if (tmo)      nxt = HALT_S;
      end
      WB1: begin
        nxt   = FETCH;
        pc_we = 1'b1;
        case (cls_q)
          C_ALU_R: rf_we = 1'b1;
          C_ALU_I, C_MOVE: begin
            rf_we   = 1'b1;
            rf_wdst = WD_RT;
          end
          C_LD: begin
            rf_we   = 1'b1;
            rf_wdst = WD_RT;
            rf_wsrc = WS_MEM;
          end
          C_PUSH: begin
            rf_we   = 1'b1;
            rf_wdst = WD_SP;
            rf_wsrc = WS_SPM4;
          end
          C_POP: begin
            rf_we   = 1'b1;
            rf_wdst = WD_RT;
            rf_wsrc = WS_MEM;
            pc_we   = 1'b0;
            nxt     = WB2;
          end
          C_CALL: begin
            rf_we   = 1'b1;
            rf_wdst = WD_SP;
            rf_wsrc = WS_SPM4;
            pc_sel  = PC_CALL;
          end
          C_RET: begin
            rf_we   = 1'b1;
            rf_wdst = WD_SP;
            rf_wsrc = WS_SPP4;
            pc_sel  = PC_MEM;
          end
          default: ;
        endcase
      end
      WB2: begin
        rf_we   = 1'b1;
        rf_wdst = WD_SP;
        rf_wsrc = WS_SPP4;
        pc_we   = 1'b1;
        nxt     = FETCH;
      end
      HALT_S:  halted = 1'b1;
      default: nxt = RESET_S;
    endcase
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed bench for risc_ctrl_fsm; stack-op scenarios run only when RISC_STACK_OPS_EN is defined.
module tb_risc_ctrl_fsm;
  // ctl = {req we asel[1:0]}_{ir pcwe pcsel[1:0]}_{imm opsel}_{rfwe wdst[1:0] wsrc[1:0]}_{halt ill}
  localparam logic [16:0] IDLE      = 17'b0000_0000_00_00000_00;
  localparam logic [16:0] FETCH_RDY = 17'b1000_1000_00_00000_00;
  localparam logic [16:0] FETCH_WT  = 17'b1000_0000_00_00000_00;
  localparam logic [16:0] DEC_ILL   = 17'b0000_0000_00_00000_01;
  localparam logic [16:0] EXEC_IMM  = 17'b0000_0000_11_00000_00;
  localparam logic [16:0] BEQ_T     = 17'b0000_0101_01_00000_00;
  localparam logic [16:0] BEQ_N     = 17'b0000_0100_01_00000_00;
  localparam logic [16:0] WB1_RD    = 17'b0000_0100_00_10000_00;
  localparam logic [16:0] WB1_RT    = 17'b0000_0100_00_10100_00;
  localparam logic [16:0] MEM_LD    = 17'b1001_0000_00_00000_00;
  localparam logic [16:0] WB1_LD    = 17'b0000_0100_00_10101_00;
  localparam logic [16:0] MEM_ST    = 17'b1101_0000_00_00000_00;
  localparam logic [16:0] PC4_ONLY  = 17'b0000_0100_00_00000_00;
  localparam logic [16:0] HALTED    = 17'b0000_0000_00_00000_10;
  localparam logic [16:0] MEM_SP    = 17'b1010_0000_00_00000_00;
  localparam logic [16:0] MEM_SPM4W = 17'b1111_0000_00_00000_00;
  localparam logic [16:0] WB1_POP   = 17'b0000_0000_00_10101_00;
  localparam logic [16:0] WB2_SP    = 17'b0000_0100_00_11010_00;
  localparam logic [16:0] WB1_CALL  = 17'b0000_0110_00_11011_00;
  localparam logic [16:0] WB1_RET   = 17'b0000_0111_00_11010_00;
  localparam logic [16:0] WB1_PUSH  = 17'b0000_0100_00_11011_00;

  logic clk = 1'b0, rst = 1'b1, zero_flag = 1'b0;
  logic [5:0] opcode = 6'b0, funct = 6'b100000;
  logic ir_we, pc_we, alu_src_imm, alu_op_sel, rf_we, halted, illegal, bus_err;
  logic [1:0] pc_sel, rf_wdst, rf_wsrc;
  logic [31:0] retired;
  logic [16:0] ctl;
  int n_cmp = 0, n_err = 0;

  risc_ctrl_fsm_if mif();

  risc_ctrl_fsm #(.MEM_TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero_flag(zero_flag), .bus(mif),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_imm(alu_src_imm),
    .alu_op_sel(alu_op_sel), .rf_we(rf_we), .rf_wdst(rf_wdst), .rf_wsrc(rf_wsrc),
    .halted(halted), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctl = {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, pc_we, pc_sel,
                alu_src_imm, alu_op_sel, rf_we, rf_wdst, rf_wsrc, halted, illegal};

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Leaves the DUT in RESET_S; the next tick lands in FETCH.
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mif.mem_ready = 1'b0; opcode = 6'b000000;
    tick(); tick();
    n_cmp++; if (ctl !== IDLE) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, IDLE); end
    n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_rtype();
    opcode = 6'b000000; mif.mem_ready = 1'b1; apply_reset();
    tick();
    n_cmp++; if (ctl !== FETCH_RDY) begin n_err++; $display("FAIL rtype_fetch: got %b want %b", ctl, FETCH_RDY); end
    tick();
    n_cmp++; if (ctl !== IDLE) begin n_err++; $display("FAIL rtype_decode: got %b want %b", ctl, IDLE); end
    tick(); tick();
    n_cmp++; if (ctl !== WB1_RD) begin n_err++; $display("FAIL rtype_wb1: got %b want %b", ctl, WB1_RD); end
    tick();
    n_cmp++; if (retired !== 32'd1) begin n_err++; $display("FAIL rtype_retired: got %0d want 1", retired); end
    n_cmp++; if (ctl !== FETCH_RDY) begin n_err++; $display("FAIL rtype_refetch: got %b want %b", ctl, FETCH_RDY); end
  endtask

  task automatic test_itype();
    opcode = 6'b001000; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick();
    n_cmp++; if (ctl !== EXEC_IMM) begin n_err++; $display("FAIL itype_exec: got %b want %b", ctl, EXEC_IMM); end
    tick();
    n_cmp++; if (ctl !== WB1_RT) begin n_err++; $display("FAIL itype_wb1: got %b want %b", ctl, WB1_RT); end
  endtask

  task automatic test_ld_wait();
    opcode = 6'b010000; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick();
    n_cmp++; if (ctl !== EXEC_IMM) begin n_err++; $display("FAIL ld_exec: got %b want %b", ctl, EXEC_IMM); end
    mif.mem_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (ctl !== MEM_LD) begin n_err++; $display("FAIL ld_mem_hold: got %b want %b", ctl, MEM_LD); end
    mif.mem_ready = 1'b1; #1;
    n_cmp++; if (ctl !== MEM_LD) begin n_err++; $display("FAIL ld_mem_ready: got %b want %b", ctl, MEM_LD); end
    tick();
    n_cmp++; if (ctl !== WB1_LD) begin n_err++; $display("FAIL ld_wb1: got %b want %b", ctl, WB1_LD); end
  endtask

  task automatic test_st();
    opcode = 6'b010001; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick(); tick();
    n_cmp++; if (ctl !== MEM_ST) begin n_err++; $display("FAIL st_mem: got %b want %b", ctl, MEM_ST); end
    tick();
    n_cmp++; if (ctl !== PC4_ONLY) begin n_err++; $display("FAIL st_wb1: got %b want %b", ctl, PC4_ONLY); end
  endtask

  task automatic test_back_to_back_beq();
    opcode = 6'b011001; mif.mem_ready = 1'b1; zero_flag = 1'b1; apply_reset();
    tick(); tick(); tick();
    n_cmp++; if (ctl !== BEQ_T) begin n_err++; $display("FAIL beq_taken: got %b want %b", ctl, BEQ_T); end
    zero_flag = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (ctl !== BEQ_N) begin n_err++; $display("FAIL beq_not_taken: got %b want %b", ctl, BEQ_N); end
    tick();
    n_cmp++; if (retired !== 32'd2) begin n_err++; $display("FAIL beq_retired: got %0d want 2", retired); end
  endtask

  task automatic test_abort();
    opcode = 6'b000000; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick(); tick();
    rst = 1'b1; #1;
    n_cmp++; if (ctl !== IDLE) begin n_err++; $display("FAIL abort_ctl: got %b want %b", ctl, IDLE); end
    tick();
    n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL abort_retired: got %0d want 0", retired); end
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    opcode = 6'b111111; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick();
    n_cmp++; if (ctl !== HALTED) begin n_err++; $display("FAIL halt_cycle3: got %b want %b", ctl, HALTED); end
    n_cmp++; if (retired !== 32'd1) begin n_err++; $display("FAIL halt_retired: got %0d want 1", retired); end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ctl !== HALTED) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
    opcode = 6'b000000; apply_reset();
    tick();
    n_cmp++; if (ctl !== FETCH_RDY) begin n_err++; $display("FAIL halt_rst_fetch: got %b want %b", ctl, FETCH_RDY); end
    n_cmp++; if (retired !== 32'd0) begin n_err++; $display("FAIL halt_rst_retired: got %0d want 0", retired); end
  endtask

  task automatic test_timeout();
    opcode = 6'b111110; mif.mem_ready = 1'b0; apply_reset();
    repeat (255) tick();
    n_cmp++; if (ctl !== FETCH_WT || bus_err !== 1'b0) begin n_err++; $display("FAIL tmo_edge: got %b/%b want %b/0", ctl, bus_err, FETCH_WT); end
    tick();
    n_cmp++; if (ctl !== HALTED) begin n_err++; $display("FAIL tmo_halted: got %b want %b", ctl, HALTED); end
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL tmo_bus_err: got %b want 1", bus_err); end
  endtask

  task automatic test_ready_at_timeout();
    opcode = 6'b111110; mif.mem_ready = 1'b0; apply_reset();
    repeat (255) tick();
    mif.mem_ready = 1'b1; #1;
    n_cmp++; if (ctl !== FETCH_RDY) begin n_err++; $display("FAIL race_fetch: got %b want %b", ctl, FETCH_RDY); end
    tick();
    n_cmp++; if (ctl !== IDLE || bus_err !== 1'b0) begin n_err++; $display("FAIL race_decode: got %b/%b want %b/0", ctl, bus_err, IDLE); end
  endtask

`ifdef RISC_STACK_OPS_EN
  task automatic test_pop();
    opcode = 6'b010011; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick();
    mif.mem_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (ctl !== MEM_SP) begin n_err++; $display("FAIL pop_mem1: got %b want %b", ctl, MEM_SP); end
    tick(); tick();
    n_cmp++; if (ctl !== MEM_SP) begin n_err++; $display("FAIL pop_mem3: got %b want %b", ctl, MEM_SP); end
    mif.mem_ready = 1'b1; #1;
    n_cmp++; if (ctl !== MEM_SP) begin n_err++; $display("FAIL pop_mem4: got %b want %b", ctl, MEM_SP); end
    tick();
    n_cmp++; if (ctl !== WB1_POP) begin n_err++; $display("FAIL pop_wb1: got %b want %b", ctl, WB1_POP); end
    tick();
    n_cmp++; if (ctl !== WB2_SP) begin n_err++; $display("FAIL pop_wb2: got %b want %b", ctl, WB2_SP); end
    tick();
    n_cmp++; if (retired !== 32'd1) begin n_err++; $display("FAIL pop_retired: got %0d want 1", retired); end
  endtask

  task automatic test_call_ret();
    opcode = 6'b010100; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick(); tick();
    n_cmp++; if (ctl !== MEM_SPM4W) begin n_err++; $display("FAIL call_mem: got %b want %b", ctl, MEM_SPM4W); end
    tick();
    n_cmp++; if (ctl !== WB1_CALL) begin n_err++; $display("FAIL call_wb1: got %b want %b", ctl, WB1_CALL); end
    tick();
    opcode = 6'b010101;
    tick(); tick(); tick();
    n_cmp++; if (ctl !== MEM_SP) begin n_err++; $display("FAIL ret_mem: got %b want %b", ctl, MEM_SP); end
    tick();
    n_cmp++; if (ctl !== WB1_RET) begin n_err++; $display("FAIL ret_wb1: got %b want %b", ctl, WB1_RET); end
    tick();
    n_cmp++; if (retired !== 32'd2) begin n_err++; $display("FAIL callret_retired: got %0d want 2", retired); end
  endtask

  task automatic test_push();
    opcode = 6'b010010; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick(); tick(); tick();
    n_cmp++; if (ctl !== MEM_SPM4W) begin n_err++; $display("FAIL push_mem: got %b want %b", ctl, MEM_SPM4W); end
    tick();
    n_cmp++; if (ctl !== WB1_PUSH) begin n_err++; $display("FAIL push_wb1: got %b want %b", ctl, WB1_PUSH); end
  endtask
`else
  task automatic test_illegal();
    opcode = 6'b010011; mif.mem_ready = 1'b1; apply_reset();
    tick(); tick();
    n_cmp++; if (ctl !== DEC_ILL) begin n_err++; $display("FAIL ill_decode: got %b want %b", ctl, DEC_ILL); end
    tick();
    n_cmp++; if (ctl !== PC4_ONLY) begin n_err++; $display("FAIL ill_wb1: got %b want %b", ctl, PC4_ONLY); end
    tick();
    n_cmp++; if (ctl !== FETCH_RDY || retired !== 32'd1) begin n_err++; $display("FAIL ill_refetch: got %b/%0d want %b/1", ctl, retired, FETCH_RDY); end
  endtask
`endif

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_ld_wait();
    test_st();
    test_back_to_back_beq();
    test_abort();
    test_halt();
    test_timeout();
    test_ready_at_timeout();
`ifdef RISC_STACK_OPS_EN
    test_pop();
    test_call_ret();
    test_push();
`else
    test_illegal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
